pipe_stall_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RISC-V core. It merges the load-use/branch stall from the hazard detector, the ID-stage branch redirect, multi-cycle mul/div occupancy in EX and data-memory wait states. From these it drives per-stage enable and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It owns the freeze state machine, a memory-wait watchdog and optional stall performance counters.

---
 rtl/pipe_stall_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl - central stall/flush sequencer for the 5-stage pipeline.
//
// Merges the hazard-detector stall, the ID branch redirect, mul/div occupancy
// in EX and data-memory wait states into per-stage enable/flush controls.
// Owns the freeze FSM (RUN / MD_WAIT / MEM_WAIT / HALT), a memory-wait
// watchdog and optional saturating stall counters.
//
// Optional feature: define PIPE_STALL_PERF_EN to build the performance
// counters; without it the counter ports are tied to zero.
//
// Parameters:
//   MEM_TO  memory-wait cycles before the watchdog trips (>= 2)
//   CNT_W   performance counter width
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   hz_stall, br_taken         hazard stall / taken branch from ID
//   md_start, md_done          mul/div issued in EX / result valid
//   mem_req, mem_ready         MEM access in progress / access completes
//   *_en                       pipeline register update enables
//   *_flush                    load a bubble into that pipeline register
//   halted                     watchdog tripped, pipeline frozen (sticky)
//   cyc/hz/md/mem/br_cnt       performance counters
module pipe_stall_ctrl #(
    parameter int MEM_TO = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hz_stall,
    input  logic             br_taken,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] hz_cnt,
    output logic [CNT_W-1:0] md_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] br_cnt
);

    localparam int WC_W = $clog2(MEM_TO) + 1;
    // Entry into MEM_WAIT already consumed one freeze cycle, so the trip
    // happens when the counter is about to reach MEM_TO-1.
    localparam logic [WC_W-1:0] TRIP_CNT = WC_W'(MEM_TO - 2);

    typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT, HALT} state_e;

    state_e          state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            md_pend_q, md_pend_d;   // MD_WAIT interrupted by a mem freeze
    logic            halted_q, halted_d;

    logic is_halt, md_ctx, mem_fz, md_fz, hz_act, br_act;

    // Freeze source decode, highest priority first.
    always_comb begin
        is_halt = (state_q == HALT);
        md_ctx  = (state_q == MD_WAIT) || ((state_q == MEM_WAIT) && md_pend_q);
        mem_fz  = mem_req && !mem_ready && !is_halt;
        // Outside an outstanding op a fresh md_start freezes; inside one,
        // md_start is irrelevant and only md_done releases.
        md_fz   = !is_halt && !mem_fz && !md_done && (md_ctx || md_start);
        hz_act  = !is_halt && !mem_fz && !md_fz && hz_stall;
        // Branch operands are not valid under any stall, so br is masked.
        br_act  = !is_halt && !mem_fz && !md_fz && !hz_stall && br_taken;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            md_pend_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            md_pend_q <= md_pend_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        md_pend_d = md_pend_q;
        halted_d  = halted_q;
        case (state_q)
            RUN, MD_WAIT: begin
                if (mem_fz) begin
                    state_d   = MEM_WAIT;
                    wcnt_d    = '0;
                    // An md_done landing on the same edge is still honoured.
                    md_pend_d = (state_q == MD_WAIT) && !md_done;
                end else if (md_fz) begin
                    state_d = MD_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_fz) begin
                    md_pend_d = md_pend_q && !md_done;
                    if (wcnt_q == TRIP_CNT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        wcnt_d   = '0;
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end else begin
                    wcnt_d    = '0;
                    md_pend_d = 1'b0;
                    state_d   = md_fz ? MD_WAIT : RUN;
                end
            end
            HALT: ;
            default: state_d = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rstn || is_halt) begin
            // everything held
        end else if (mem_fz) begin
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (md_fz) begin
            ex_mem_en    = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_en    = 1'b1;
        end else if (hz_act) begin
            id_ex_en     = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
        end else begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = br_act;
        end
    end

    assign halted = halted_q;

`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] cyc_q, hz_q, md_q, mem_q, br_q;
    logic [CNT_W-1:0] cyc_d, hz_d, md_d, mem_d, br_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        cyc_d = sat_inc(cyc_q, 1'b1);
        hz_d  = sat_inc(hz_q,  hz_act);
        md_d  = sat_inc(md_q,  md_fz);
        mem_d = sat_inc(mem_q, mem_fz);
        br_d  = sat_inc(br_q,  br_act);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
            hz_q  <= '0;
            md_q  <= '0;
            mem_q <= '0;
            br_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            hz_q  <= hz_d;
            md_q  <= md_d;
            mem_q <= mem_d;
            br_q  <= br_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign hz_cnt  = hz_q;
    assign md_cnt  = md_q;
    assign mem_cnt = mem_q;
    assign br_cnt  = br_q;
`else
    assign cyc_cnt = '0;
    assign hz_cnt  = '0;
    assign md_cnt  = '0;
    assign mem_cnt = '0;
    assign br_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl (MEM_TO=4, CNT_W=4). A per-cycle reference model
// tracks "md op outstanding", the consecutive mem-freeze streak and a halted
// flag, and picks the winning freeze rule in priority order.
module tb_pipe_stall_ctrl;
    localparam int MEM_TO = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic hz_stall = 0, br_taken = 0, md_start = 0, md_done = 0;
    logic mem_req = 0, mem_ready = 0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;
    logic [CNT_W-1:0] cyc_cnt, hz_cnt, md_cnt, mem_cnt, br_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .hz_stall(hz_stall), .br_taken(br_taken),
        .md_start(md_start), .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halted(halted),
        .cyc_cnt(cyc_cnt), .hz_cnt(hz_cnt), .md_cnt(md_cnt), .mem_cnt(mem_cnt), .br_cnt(br_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit m_halt, m_busy;
    int m_streak;
    int m_cyc, m_hz, m_md, m_mem, m_br;

    // 0 = reset, 1 = halt, 2 = mem, 3 = md, 4 = hazard, 5 = branch, 6 = run
    function automatic int rule_of();
        if (!rstn) return 0;
        if (m_halt) return 1;
        if (mem_req && !mem_ready) return 2;
        if ((m_busy || md_start) && !md_done) return 3;
        if (hz_stall) return 4;
        if (br_taken) return 5;
        return 6;
    endfunction

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes}
    function automatic logic [8:0] ctl_of(input int r);
        case (r)
            2: return 9'b00001_0001;
            3: return 9'b00011_0010;
            4: return 9'b00111_0100;
            5: return 9'b11111_1000;
            6: return 9'b11111_0000;
            default: return 9'b00000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input int r);
        check("ctl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}),
              32'(ctl_of(r)));
        check("halted", 32'(halted), 32'(m_halt));
`ifdef PIPE_STALL_PERF_EN
        check("cyc_cnt", 32'(cyc_cnt), m_cyc);
        check("hz_cnt",  32'(hz_cnt),  m_hz);
        check("md_cnt",  32'(md_cnt),  m_md);
        check("mem_cnt", 32'(mem_cnt), m_mem);
        check("br_cnt",  32'(br_cnt),  m_br);
`else
        check("cnt_off", 32'({cyc_cnt, hz_cnt, md_cnt, mem_cnt, br_cnt}), 32'd0);
`endif
    endtask

    task automatic model_reset();
        m_halt = 0; m_busy = 0; m_streak = 0;
        m_cyc = 0; m_hz = 0; m_md = 0; m_mem = 0; m_br = 0;
    endtask

    task automatic model_adv(input int r, input logic done);
        if (m_cyc < CMAX) m_cyc++;
        if (r == 4 && m_hz  < CMAX) m_hz++;
        if (r == 3 && m_md  < CMAX) m_md++;
        if (r == 2 && m_mem < CMAX) m_mem++;
        if (r == 5 && m_br  < CMAX) m_br++;
        case (r)
            2: begin
                m_streak++;
                if (done) m_busy = 0;
                if (m_streak == MEM_TO) m_halt = 1;
            end
            3: begin m_streak = 0; m_busy = 1; end
            4, 5, 6: begin m_streak = 0; m_busy = 0; end
            default: ;
        endcase
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic step(input logic h, input logic b, input logic ms, input logic md,
                        input logic mq, input logic mr);
        int r;
        hz_stall = h; br_taken = b; md_start = ms; md_done = md;
        mem_req = mq; mem_ready = mr;
        #2;
        r = rule_of();
        check_all(r);
        @(posedge clk);
        model_adv(r, md);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check_all(0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #1;
        model_reset();
        check_all(0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // single hazard pulse
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // branch masked by hazard, then taken alone
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // md_start at t0, md_done at t4
        step(0, 0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // mem wait of 3 cycles inside MD_WAIT, mem_ready first
        step(0, 0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // md_done arriving during the mem wait
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        // same-cycle start/done, and ready in the first mem cycle
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        // watchdog: exactly MEM_TO freeze cycles trip it
        repeat (MEM_TO) step(0, 0, 0, 0, 1, 0);
        check("wd_halted", 32'(halted), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 1);
        do_reset();
        check("rst_halted", 32'(halted), 32'd0);
        // one cycle short of the watchdog must not halt
        repeat (MEM_TO - 1) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        check("no_trip", 32'(halted), 32'd0);
        // reset mid-MD_WAIT abandons the op
        step(0, 0, 1, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        // counter saturation
        do_reset();
        repeat (20) step(1, 0, 0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        check("hz_sat",  32'(hz_cnt),  32'd15);
        check("cyc_sat", 32'(cyc_cnt), 32'd15);
`else
        check("hz_off",  32'(hz_cnt),  32'd0);
        check("cyc_off", 32'(cyc_cnt), 32'd0);
`endif
        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ((m_halt && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 149) == 0))
                do_reset();
            else
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
